// File: rtl/heater_temp_monitor.sv
// heater_temp_monitor
//   Upstream stage of the heater. Block-averages raw temperature samples,
//   drives the heater on/off request with hysteresis, and latches a fault on
//   over-temperature persistence or a sensor timeout.
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   sample_valid in   raw sample strobe, one sample per high cycle
//   sample_data  in   raw temperature code (DATA_W)
//   err_clear    in   single-cycle fault clear request
//   temp_avg     out  last completed average (DATA_W)
//   temp_valid   out  1-cycle pulse, temp_avg updated this cycle
//   heat_req     out  heater on request (forced low while error)
//   error        out  latched fault
//   error_code   out  01 over-temp, 10 sensor timeout, 00 none
module heater_temp_monitor #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned SETPOINT = 2000,
  parameter int unsigned HYST     = 20,
  parameter int unsigned TRIP     = 2500,
  parameter int unsigned TRIP_CNT = 3,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              err_clear,
  output logic [DATA_W-1:0] temp_avg,
  output logic              temp_valid,
  output logic              heat_req,
  output logic              error,
  output logic [1:0]        error_code
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned PER_W = $clog2(TRIP_CNT + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);
  localparam logic [DATA_W-1:0] LO_TH    = DATA_W'(SETPOINT - HYST);
  localparam logic [DATA_W-1:0] HI_TH    = DATA_W'(SETPOINT + HYST);
  localparam logic [DATA_W-1:0] TRIP_TH  = DATA_W'(TRIP);
  localparam logic [PER_W-1:0]  PER_MAX  = PER_W'(TRIP_CNT);
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_OVER    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_e;

  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              tvalid_q, tvalid_d;
  logic              heat_q, heat_d;
  logic [PER_W-1:0]  persist_q, persist_d, persist_nxt;
  logic [WD_W-1:0]   wdog_q, wdog_d, wdog_nxt;
  logic              error_q, error_d;
  err_code_e         code_q, code_d;
  logic              over_evt, to_evt;

  always_comb begin
    acc_sum  = acc_q + ACC_W'(sample_data);
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    avg_d    = avg_q;
    tvalid_d = 1'b0;
    if (sample_valid) begin
      if (cnt_q == CNT_LAST) begin
        avg_d    = DATA_W'(acc_sum >> AVG_LOG2);
        acc_d    = '0;
        cnt_d    = '0;
        tvalid_d = 1'b1;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Hysteresis and persistence act on the registered average during its
  // temp_valid cycle, so both see exactly the value presented on temp_avg.
  always_comb begin
    heat_d      = heat_q;
    persist_nxt = persist_q;
    over_evt    = 1'b0;
    if (tvalid_q) begin
      if (avg_q < LO_TH) begin
        heat_d = 1'b1;
      end else if (avg_q >= HI_TH) begin
        heat_d = 1'b0;
      end
      if (avg_q > TRIP_TH) begin
        if (persist_q < PER_MAX) begin
          persist_nxt = persist_q + PER_W'(1);
          over_evt    = (persist_q == PER_MAX - PER_W'(1));
        end
      end else begin
        persist_nxt = '0;
      end
    end
  end

  always_comb begin
    wdog_nxt = wdog_q;
    to_evt   = 1'b0;
    if (sample_valid) begin
      wdog_nxt = '0;
    end else if (wdog_q < WD_MAX) begin
      wdog_nxt = wdog_q + WD_W'(1);
      to_evt   = (wdog_q == WD_MAX - WD_W'(1));
    end
  end

  // A fault event overrides a simultaneous clear; the clear still lets the
  // new cause replace the latched one.
  always_comb begin
    error_d   = error_q;
    code_d    = code_q;
    persist_d = persist_nxt;
    wdog_d    = wdog_nxt;
    if (over_evt || to_evt) begin
      error_d = 1'b1;
      if (!error_q || err_clear) begin
        code_d = over_evt ? ERR_OVER : ERR_TIMEOUT;
      end
    end else if (err_clear && error_q) begin
      error_d   = 1'b0;
      code_d    = ERR_NONE;
      persist_d = '0;
      wdog_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      tvalid_q  <= 1'b0;
      heat_q    <= 1'b0;
      persist_q <= '0;
      wdog_q    <= '0;
      error_q   <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      tvalid_q  <= tvalid_d;
      heat_q    <= heat_d;
      persist_q <= persist_d;
      wdog_q    <= wdog_d;
      error_q   <= error_d;
      code_q    <= code_d;
    end
  end

  assign temp_avg   = avg_q;
  assign temp_valid = tvalid_q;
  assign heat_req   = heat_q & ~error_q;
  assign error      = error_q;
  assign error_code = code_q;

endmodule

// File: tb/tb_heater_temp_monitor.sv
module tb_heater_temp_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic        err_clear;
  logic [11:0] temp_avg;
  logic        temp_valid;
  logic        heat_req;
  logic        error;
  logic [1:0]  error_code;

  heater_temp_monitor #(
    .DATA_W(12), .AVG_LOG2(3), .SETPOINT(2000), .HYST(20),
    .TRIP(2500), .TRIP_CNT(3), .TIMEOUT(1000)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .sample_data(sample_data), .err_clear(err_clear),
    .temp_avg(temp_avg), .temp_valid(temp_valid), .heat_req(heat_req),
    .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned avg;
    bit          heat;
    bit          err;
    int unsigned code;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned win[8];

  // Reference model state, expressed in the spec's terms
  bit          m_heat;
  int unsigned m_persist;
  bit          m_err;
  int unsigned m_code;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic void model_reset();
    m_heat = 0; m_persist = 0; m_err = 0; m_code = 0;
  endfunction

  function automatic exp_t model_window(input int unsigned sum, input bit clr);
    exp_t e;
    int unsigned avg;
    bit evt;
    avg = sum / 8;
    evt = 0;
    if (avg < 1980) m_heat = 1;
    else if (avg >= 2020) m_heat = 0;
    if (avg > 2500) begin
      if (m_persist < 3) begin
        m_persist++;
        if (m_persist == 3) evt = 1;
      end
    end else begin
      m_persist = 0;
    end
    if (evt) begin
      if (!m_err || clr) m_code = 1;
      m_err = 1;
    end else if (clr && m_err) begin
      m_err = 0; m_code = 0; m_persist = 0;
    end
    e.avg = avg; e.heat = m_heat && !m_err; e.err = m_err; e.code = m_code;
    return e;
  endfunction

  // Monitor: temp_avg checked in the temp_valid cycle, the resulting
  // heat/error state one cycle later.
  exp_t cur;
  bit   pending = 0;
  always @(negedge clk) begin
    if (pending) begin
      check("heat_req", heat_req, cur.heat);
      check("error", error, cur.err);
      check("error_code", error_code, cur.code);
      pending = 0;
    end
    if (temp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_temp_valid", 1, 0);
      end else begin
        cur = sb.pop_front();
        check("temp_avg", temp_avg, cur.avg);
        pending = 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_window(input bit clr, input int unsigned maxgap);
    int unsigned sum = 0;
    for (int i = 0; i < 8; i++) begin
      sample_valid = 1;
      sample_data  = 12'(win[i]);
      sum += win[i];
      if (i == 7) sb.push_back(model_window(sum, clr));
      tick(1);
      sample_valid = 0;
      if (i < 7) tick($urandom_range(0, maxgap));
    end
    err_clear = clr;
    tick(1);
    err_clear = 0;
  endtask

  task automatic fill(input int unsigned v);
    for (int i = 0; i < 8; i++) win[i] = v;
  endtask

  task automatic clear_pulse();
    err_clear = 1;
    tick(1);
    err_clear = 0;
    if (m_err) begin m_err = 0; m_code = 0; m_persist = 0; end
    check("clear_error", error, m_err);
    check("clear_code", error_code, m_code);
    check("clear_heat", heat_req, m_heat && !m_err);
  endtask

  initial begin
    int unsigned base;
    reset = 1; sample_valid = 0; sample_data = '0; err_clear = 0;
    model_reset();
    tick(3);
    check("rst_temp_avg", temp_avg, 0);
    check("rst_temp_valid", temp_valid, 0);
    check("rst_heat_req", heat_req, 0);
    check("rst_error", error, 0);
    check("rst_error_code", error_code, 0);
    reset = 0;
    tick(1);

    // Cold start, then hysteresis band edges
    fill(1900); run_window(0, 2);
    fill(2010); run_window(0, 2);
    fill(2020); run_window(0, 2);
    fill(1979); run_window(0, 2);

    // Over-temp persistence
    fill(2600); run_window(0, 1);
    run_window(0, 1);
    run_window(0, 1);
    clear_pulse();
    run_window(0, 1);
    run_window(0, 1);
    fill(2400); run_window(0, 1);
    fill(2600); run_window(0, 1);
    fill(2000); run_window(0, 1);

    // Sensor timeout, clear, re-trip
    tick(985);
    check("wd_early_error", error, 0);
    tick(30);
    m_err = 1; m_code = 2;
    check("wd_error", error, 1);
    check("wd_code", error_code, 2);
    check("wd_heat", heat_req, 0);
    clear_pulse();
    tick(985);
    check("wd2_early_error", error, 0);
    tick(30);
    m_err = 1; m_code = 2;
    check("wd2_error", error, 1);
    check("wd2_code", error_code, 2);

    // Third over-temp average coinciding with a clear: new cause latched
    fill(2600); run_window(0, 0);
    run_window(0, 0);
    run_window(1, 0);
    clear_pulse();

    // Reset mid-window discards the partial sum
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1; sample_data = 12'd3000;
      tick(1);
    end
    sample_valid = 0;
    reset = 1;
    tick(2);
    reset = 0;
    model_reset();
    tick(1);
    check("mid_rst_temp_avg", temp_avg, 0);
    check("mid_rst_error", error, 0);
    for (int i = 0; i < 8; i++) win[i] = $urandom_range(1800, 2200);
    run_window(0, 2);

    // Randomized windows around setpoint and trip
    for (int w = 0; w < 30; w++) begin
      base = ($urandom_range(0, 3) == 0) ? $urandom_range(2450, 2700) : $urandom_range(1900, 2100);
      for (int i = 0; i < 8; i++) win[i] = base + $urandom_range(0, 60) - 30;
      run_window($urandom_range(0, 5) == 0, 3);
      if ($urandom_range(0, 4) == 0) clear_pulse();
    end

    tick(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
